// File: rtl/dds_pkg.sv
// Constants shared by the DDS sweep controller and the phase accumulator, plus the
// sweep controller state encoding.
package dds_pkg;

  localparam int          DDS_FW_WIDTH     = 32;
  localparam logic [31:0] DDS_F_MIN        = 32'd86;
  localparam logic [31:0] DDS_F_MAX        = 32'd858994;
  localparam logic [31:0] DDS_F_STEP       = 32'd859;
  localparam int          DDS_DWELL_CYCLES = 50_000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUSH,
    ST_DWELL,
    ST_STEP
  } sweep_state_t;

  // Counter width that still holds n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Dwell counter for one sweep point: counts 0..DWELL_CYCLES-1 while enabled,
// expire flags the terminal count; clear forces the count back to zero.
module dwell_timer
  import dds_pkg::*;
#(
  parameter int DWELL_CYCLES = DDS_DWELL_CYCLES
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int            CW   = cnt_width(DWELL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] count;

  assign expire = enable && (count == LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep/step controller: turns key flags into tuning words and hands each new
// word to the phase accumulator over valid/ready; automatic sweep dwells at every point.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int                  FW_WIDTH     = DDS_FW_WIDTH,
  parameter logic [FW_WIDTH-1:0] F_MIN        = FW_WIDTH'(DDS_F_MIN),
  parameter logic [FW_WIDTH-1:0] F_MAX        = FW_WIDTH'(DDS_F_MAX),
  parameter logic [FW_WIDTH-1:0] F_STEP       = FW_WIDTH'(DDS_F_STEP),
  parameter int                  DWELL_CYCLES = DDS_DWELL_CYCLES
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                start_flag,
  input  logic                stop_flag,
  input  logic                up_flag,
  input  logic                dn_flag,
  input  logic                sweep_down,
  input  logic                loop_en,
  input  logic                cfg_ready,
  output logic [FW_WIDTH-1:0] freq_word,
  output logic                cfg_valid,
  output logic                sweeping,
  output logic                sweep_done
);

  sweep_state_t        state, state_nxt, ret, ret_nxt;
  logic [FW_WIDTH-1:0] word_nxt;
  logic                valid_nxt, done_nxt;
  logic                dir, dir_nxt;
  logic                stop_pend, stop_pend_nxt;
  logic                dwell_exp;

  // One extra bit so stepping past either end of the range is detected instead of wrapping.
  logic [FW_WIDTH:0]   inc, dec;
  logic                up_over, dn_under;
  logic [FW_WIDTH-1:0] up_clamp, dn_clamp, start_word;

  assign inc        = {1'b0, freq_word} + {1'b0, F_STEP};
  assign dec        = {1'b0, freq_word} - {1'b0, F_STEP};
  assign up_over    = inc > {1'b0, F_MAX};
  assign dn_under   = dec[FW_WIDTH] || (dec < {1'b0, F_MIN});
  assign up_clamp   = up_over  ? F_MAX : inc[FW_WIDTH-1:0];
  assign dn_clamp   = dn_under ? F_MIN : dec[FW_WIDTH-1:0];
  assign start_word = dir ? F_MAX : F_MIN;

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clear    (state != ST_DWELL),
    .enable   (state == ST_DWELL),
    .expire   (dwell_exp)
  );

  always_comb begin
    state_nxt     = state;
    ret_nxt       = ret;
    word_nxt      = freq_word;
    valid_nxt     = cfg_valid;
    done_nxt      = 1'b0;
    dir_nxt       = dir;
    stop_pend_nxt = stop_pend;
    case (state)
      ST_IDLE: begin
        if (!stop_flag) begin
          if (start_flag) begin
            dir_nxt   = sweep_down;
            word_nxt  = sweep_down ? F_MAX : F_MIN;
            valid_nxt = 1'b1;
            state_nxt = ST_PUSH;
            ret_nxt   = ST_DWELL;
          end else if (up_flag || dn_flag) begin
            word_nxt  = up_flag ? up_clamp : dn_clamp;
            valid_nxt = 1'b1;
            state_nxt = ST_PUSH;
            ret_nxt   = ST_IDLE;
          end
        end
      end
      ST_PUSH: begin
        // A stop arriving mid-transfer waits for the handshake; valid is never withdrawn.
        if (cfg_ready) begin
          valid_nxt     = 1'b0;
          stop_pend_nxt = 1'b0;
          state_nxt     = (stop_pend || stop_flag) ? ST_IDLE : ret;
        end else if (stop_flag) begin
          stop_pend_nxt = 1'b1;
        end
      end
      ST_DWELL: begin
        if (stop_flag) begin
          state_nxt = ST_IDLE;
        end else if (dwell_exp) begin
          state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        if (stop_flag) begin
          state_nxt = ST_IDLE;
        end else if (dir ? dn_under : up_over) begin
          if (loop_en) begin
            word_nxt  = start_word;
            valid_nxt = 1'b1;
            state_nxt = ST_PUSH;
            ret_nxt   = ST_DWELL;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else begin
          word_nxt  = dir ? dec[FW_WIDTH-1:0] : inc[FW_WIDTH-1:0];
          valid_nxt = 1'b1;
          state_nxt = ST_PUSH;
          ret_nxt   = ST_DWELL;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      ret        <= ST_IDLE;
      freq_word  <= F_MIN;
      cfg_valid  <= 1'b0;
      sweeping   <= 1'b0;
      sweep_done <= 1'b0;
      dir        <= 1'b0;
      stop_pend  <= 1'b0;
    end else begin
      state      <= state_nxt;
      ret        <= ret_nxt;
      freq_word  <= word_nxt;
      cfg_valid  <= valid_nxt;
      sweeping   <= (state_nxt != ST_IDLE);
      sweep_done <= done_nxt;
      dir        <= dir_nxt;
      stop_pend  <= stop_pend_nxt;
    end
  end

endmodule
